// File: rtl/pe_gate_scheduler.sv
// pe_gate_scheduler: walks a programmable table of (PE mask, sleep count, last)
// entries. Each entry loads the selected PE gating counters with a broadcast
// count, then waits until every selected PE reports its gate-enable high again.
module pe_gate_scheduler #(
  parameter int N_PE  = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 5,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Global_Stall_I,
  input  logic              Cfg_We,
  input  logic [AW-1:0]     Cfg_Addr,
  input  logic [N_PE-1:0]   Cfg_Mask,
  input  logic [CNT_W-1:0]  Cfg_Count,
  input  logic              Cfg_Last,
  input  logic              Start,
  input  logic              Abort,
  input  logic [N_PE-1:0]   Gate_Done_I,
  output logic [N_PE-1:0]   Counter_En_O,
  output logic [CNT_W-1:0]  Data_O,
  output logic              Busy_O,
  output logic              Done_O,
  output logic [AW-1:0]     Entry_Idx_O
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic              r_busy;
  logic              r_done;

  logic [N_PE-1:0]   r_mask [DEPTH];
  logic [CNT_W-1:0]  r_cnt  [DEPTH];
  logic              r_last [DEPTH];

  logic [N_PE-1:0]   w_mask;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_last;
  logic              w_skip;
  logic              w_final;
  logic              w_gate_ok;
  logic              w_advance;
  logic              w_cfg_ok;

  assign w_mask    = r_mask[r_idx];
  assign w_cnt     = r_cnt[r_idx];
  assign w_last    = r_last[r_idx];
  // A zero count would make the counters wrap to their maximum, so it is
  // treated like an empty mask and the entry is passed over.
  assign w_skip    = (w_mask == '0) || (w_cnt == '0);
  assign w_final   = w_last || (r_idx == AW'(DEPTH - 1));
  assign w_gate_ok = ((Gate_Done_I & w_mask) == w_mask);
  assign w_advance = ((r_state == S_ISSUE) && w_skip) ||
                     ((r_state == S_WAIT) && w_gate_ok);
  assign w_cfg_ok  = (r_state == S_IDLE) || (r_state == S_DONE);

  // Load strobe is combinational so the counters capture at the ISSUE edge;
  // a stall suppresses it so a frozen ISSUE cannot reload repeatedly.
  assign Counter_En_O = ((r_state == S_ISSUE) && !w_skip && !Global_Stall_I) ? w_mask : '0;
  assign Data_O       = ((r_state == S_ISSUE) && !w_skip) ? w_cnt : '0;
  assign Busy_O       = r_busy;
  assign Done_O       = r_done;
  assign Entry_Idx_O  = r_idx;

  // Schedule table: writable only while no schedule is running.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mask[i] <= '0;
        r_cnt[i]  <= '0;
        r_last[i] <= 1'b0;
      end
    end else if (Cfg_We && w_cfg_ok) begin
      r_mask[Cfg_Addr] <= Cfg_Mask;
      r_cnt[Cfg_Addr]  <= Cfg_Count;
      r_last[Cfg_Addr] <= Cfg_Last;
    end
  end

  // Sequencer FSM with registered Busy/Done; Abort overrides stall.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (Abort) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!Global_Stall_I) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_state <= S_ISSUE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (w_advance) begin
            if (w_final) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_idx   <= r_idx + AW'(1);
            end
          end else if (r_state == S_ISSUE) begin
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
